// File: rtl/sprite_rom_if.sv
// ============================================================================
// Module   : sprite_rom_if
// Purpose  : Tank pixel request, sprite ROM and pixel return bundle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface sprite_rom_if;
    logic        req1;
    logic [2:0]  dir1;
    logic [9:0]  offs1;
    logic        req2;
    logic [2:0]  dir2;
    logic [9:0]  offs2;
    logic        gnt1;
    logic        gnt2;
    logic [9:0]  rom_addr;
    logic [1:0]  rom_sel;
    logic [23:0] rom_data;
    logic        rvalid1;
    logic        rvalid2;
    logic [23:0] rdata;
    logic        ropaque;

    modport slave (
        input  req1, dir1, offs1, req2, dir2, offs2, rom_data,
        output gnt1, gnt2, rom_addr, rom_sel, rvalid1, rvalid2, rdata, ropaque
    );

    modport master (
        output req1, dir1, offs1, req2, dir2, offs2, rom_data,
        input  gnt1, gnt2, rom_addr, rom_sel, rvalid1, rvalid2, rdata, ropaque
    );
endinterface

`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
// ============================================================================
// Module   : sprite_rom_arbiter
// Purpose  : Round-robin sharing of the four direction tank sprite ROMs between
//            two pixel requesters, with fixed-latency tagged pixel return.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sprite_rom_arbiter #(
    parameter int          ROM_LAT = 1,
    parameter logic [23:0] KEY_RGB = 24'hFF0000
) (
    input  wire logic   Clk,
    input  wire logic   Reset,
    sprite_rom_if.slave bus
);

    typedef enum logic [0:0] {
        TANK1 = 1'b0,
        TANK2 = 1'b1
    } tank_e;

    typedef struct packed {
        logic  vld;
        tank_e id;
        logic  bad;
    } tag_t;

    tank_e       r_last;
    tank_e       w_last_next;
    logic        w_gnt1;
    logic        w_gnt2;
    logic        w_any;
    logic [2:0]  w_dir;
    logic [9:0]  w_offs;
    logic [1:0]  w_sel;
    logic        w_bad;
    logic [9:0]  r_rom_addr;
    logic [1:0]  r_rom_sel;
    tag_t        r_tag [ROM_LAT+1];
    tag_t        w_ret;
    logic        r_rvalid1;
    logic        r_rvalid2;
    logic [23:0] r_rdata;
    logic        r_ropaque;

    // Grant state: remembers which tank was served last.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_last <= TANK2;
        end else begin
            r_last <= w_last_next;
        end
    end

    always_comb begin
        w_gnt1      = 1'b0;
        w_gnt2      = 1'b0;
        w_last_next = r_last;
        if (!Reset) begin
            if (bus.req1 && (!bus.req2 || r_last == TANK2)) begin
                w_gnt1 = 1'b1;
            end else if (bus.req2) begin
                w_gnt2 = 1'b1;
            end
        end
        if (w_gnt1) begin
            w_last_next = TANK1;
        end else if (w_gnt2) begin
            w_last_next = TANK2;
        end
    end

    assign w_any  = w_gnt1 | w_gnt2;
    assign w_dir  = w_gnt1 ? bus.dir1  : bus.dir2;
    assign w_offs = w_gnt1 ? bus.offs1 : bus.offs2;

    always_comb begin
        w_sel = 2'd0;
        w_bad = 1'b0;
        case (w_dir)
            3'd1:    w_sel = 2'd0;
            3'd2:    w_sel = 2'd1;
            3'd3:    w_sel = 2'd2;
            3'd4:    w_sel = 2'd3;
            default: w_bad = 1'b1;
        endcase
    end

    // Address and bank hold their value across idle cycles.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rom_addr <= 10'd0;
            r_rom_sel  <= 2'd0;
        end else if (w_any) begin
            r_rom_addr <= w_bad ? 10'd0 : w_offs;
            r_rom_sel  <= w_sel;
        end
    end

    // Tag pipeline: stage ROM_LAT lines up with rom_data of the same request.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k <= ROM_LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= '{vld: w_any, id: (w_gnt2 ? TANK2 : TANK1), bad: w_bad};
            for (int k = 1; k <= ROM_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    assign w_ret = r_tag[ROM_LAT];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rvalid1 <= 1'b0;
            r_rvalid2 <= 1'b0;
            r_rdata   <= 24'd0;
            r_ropaque <= 1'b0;
        end else begin
            r_rvalid1 <= w_ret.vld && (w_ret.id == TANK1);
            r_rvalid2 <= w_ret.vld && (w_ret.id == TANK2);
            if (w_ret.vld) begin
                r_rdata   <= w_ret.bad ? KEY_RGB : bus.rom_data;
                r_ropaque <= !w_ret.bad && (bus.rom_data != KEY_RGB);
            end
        end
    end

    assign bus.gnt1     = w_gnt1;
    assign bus.gnt2     = w_gnt2;
    assign bus.rom_addr = r_rom_addr;
    assign bus.rom_sel  = r_rom_sel;
    assign bus.rvalid1  = r_rvalid1;
    assign bus.rvalid2  = r_rvalid2;
    assign bus.rdata    = r_rdata;
    assign bus.ropaque  = r_ropaque;

endmodule

`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
// ============================================================================
// Module   : tb_sprite_rom_arbiter
// Purpose  : Random and directed checks of sprite_rom_arbiter at ROM_LAT 1 and 3.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sprite_rom_arbiter;

    localparam int          c_lat_a = 1;
    localparam int          c_lat_b = 3;
    localparam logic [23:0] c_key   = 24'hFF0000;
    localparam int          c_maxc  = 4096;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       req1 = 1'b0, req2 = 1'b0;
    logic [2:0] dir1 = 3'd0, dir2 = 3'd0;
    logic [9:0] offs1 = 10'd0, offs2 = 10'd0;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always #5 Clk = ~Clk;

    sprite_rom_if if_a ();
    sprite_rom_if if_b ();

    assign if_a.req1 = req1;  assign if_a.dir1 = dir1;  assign if_a.offs1 = offs1;
    assign if_a.req2 = req2;  assign if_a.dir2 = dir2;  assign if_a.offs2 = offs2;
    assign if_b.req1 = req1;  assign if_b.dir1 = dir1;  assign if_b.offs1 = offs1;
    assign if_b.req2 = req2;  assign if_b.dir2 = dir2;  assign if_b.offs2 = offs2;

    sprite_rom_arbiter #(.ROM_LAT(c_lat_a), .KEY_RGB(c_key)) dut_a (
        .Clk(Clk), .Reset(Reset), .bus(if_a.slave));
    sprite_rom_arbiter #(.ROM_LAT(c_lat_b), .KEY_RGB(c_key)) dut_b (
        .Clk(Clk), .Reset(Reset), .bus(if_b.slave));

    // Sprite ROM contents: a few fixed pixels, key colour on every offset = 3 mod 8.
    function automatic logic [23:0] rom_word(input int bank, input int addr);
        logic [23:0] v;
        if (bank == 0 && addr == 5)  return 24'h123456;
        if (bank == 2 && addr == 33) return 24'hFF0000;
        if ((addr % 8) == 3)         return 24'hFF0000;
        v = 24'(bank + 1) * 24'h010203;
        v = v ^ (24'(addr) * 24'h000B17) ^ 24'h5A0000;
        return v;
    endfunction

    logic [23:0] pa [0:3];
    logic [23:0] pb [0:3];

    always @(posedge Clk) begin
        pa[0] <= rom_word(int'(if_a.rom_sel), int'(if_a.rom_addr));
        pb[0] <= rom_word(int'(if_b.rom_sel), int'(if_b.rom_addr));
        for (int k = 1; k < 4; k++) begin
            pa[k] <= pa[k-1];
            pb[k] <= pb[k-1];
        end
    end

    assign if_a.rom_data = pa[c_lat_a-1];
    assign if_b.rom_data = pb[c_lat_b-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    bit          ev1 [2][c_maxc];
    bit          ev2 [2][c_maxc];
    logic [23:0] edat [2][c_maxc];
    bit          eopq [2][c_maxc];
    int          m_last = 2;
    int          m_addr = 0;
    int          m_sel  = 0;
    int          m_win;
    int          m_dir;
    int          m_off;
    bit          m_ok;
    logic [23:0] m_data;

    always @(negedge Clk) begin
        check("gnt1_a", if_a.gnt1, (!Reset && req1 && (!req2 || m_last == 2)) ? 1 : 0);
        if (Reset) begin
            check("gnt2_a_rst", if_a.gnt2, 0);
            m_last = 2;
            m_addr = 0;
            m_sel  = 0;
            for (int k = cyc + 1; k < cyc + 8; k++) begin
                for (int d = 0; d < 2; d++) begin
                    ev1[d][k] = 0;
                    ev2[d][k] = 0;
                end
            end
        end else begin
            check("rom_addr_a", if_a.rom_addr, m_addr);
            check("rom_sel_a",  if_a.rom_sel,  m_sel);
            check("rom_addr_b", if_b.rom_addr, m_addr);
            check("rom_sel_b",  if_b.rom_sel,  m_sel);
            check("rvalid1_a", if_a.rvalid1, ev1[0][cyc]);
            check("rvalid2_a", if_a.rvalid2, ev2[0][cyc]);
            check("rvalid1_b", if_b.rvalid1, ev1[1][cyc]);
            check("rvalid2_b", if_b.rvalid2, ev2[1][cyc]);
            if (ev1[0][cyc] || ev2[0][cyc]) begin
                check("rdata_a",   if_a.rdata,   edat[0][cyc]);
                check("ropaque_a", if_a.ropaque, eopq[0][cyc]);
            end
            if (ev1[1][cyc] || ev2[1][cyc]) begin
                check("rdata_b",   if_b.rdata,   edat[1][cyc]);
                check("ropaque_b", if_b.ropaque, eopq[1][cyc]);
            end
            m_win = 0;
            if (req1 && req2)  m_win = (m_last == 2) ? 1 : 2;
            else if (req1)     m_win = 1;
            else if (req2)     m_win = 2;
            check("gnt2_a", if_a.gnt2, m_win == 2);
            check("gnt1_b", if_b.gnt1, m_win == 1);
            check("gnt2_b", if_b.gnt2, m_win == 2);
            if (m_win != 0) begin
                m_dir  = (m_win == 1) ? int'(dir1)  : int'(dir2);
                m_off  = (m_win == 1) ? int'(offs1) : int'(offs2);
                m_ok   = (m_dir >= 1 && m_dir <= 4);
                m_addr = m_ok ? m_off : 0;
                m_sel  = m_ok ? m_dir - 1 : 0;
                m_data = m_ok ? rom_word(m_dir - 1, m_off) : c_key;
                for (int d = 0; d < 2; d++) begin
                    int due;
                    due = cyc + 2 + ((d == 0) ? c_lat_a : c_lat_b);
                    ev1[d][due]  = (m_win == 1);
                    ev2[d][due]  = (m_win == 2);
                    edat[d][due] = m_data;
                    eopq[d][due] = m_ok && (m_data != c_key);
                end
                m_last = m_win;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        next_cycle();
        next_cycle();
        Reset = 1'b0;
    endtask

    function automatic logic [2:0] pick_dir();
        if ($urandom_range(0, 7) == 0) return 3'($urandom_range(5, 7)) & 3'b111 & ($urandom_range(0, 1) ? 3'd0 : 3'd7);
        return 3'($urandom_range(1, 4));
    endfunction

    bit g1s, g2s;

    initial begin
        repeat (3) next_cycle();
        at_sample();
        check("rst_gnt1",    if_a.gnt1, 0);
        check("rst_rvalid1", if_a.rvalid1, 0);
        check("rst_rvalid2", if_a.rvalid2, 0);
        check("rst_rdata",   if_a.rdata, 0);
        check("rst_ropaque", if_a.ropaque, 0);
        check("rst_addr",    if_a.rom_addr, 0);
        check("rst_sel",     if_a.rom_sel, 0);
        next_cycle();
        Reset = 1'b0;

        // single tank1 request, up sprite offset 5
        req1 = 1'b1; dir1 = 3'd1; offs1 = 10'd5;
        at_sample();
        check("t1_gnt1", if_a.gnt1, 1);
        next_cycle(); req1 = 1'b0;
        at_sample();
        check("t1_addr", if_a.rom_addr, 5);
        check("t1_sel",  if_a.rom_sel, 0);
        next_cycle(); next_cycle();
        at_sample();
        check("t1_rvalid1", if_a.rvalid1, 1);
        check("t1_rdata",   if_a.rdata, 24'h123456);
        check("t1_ropaque", if_a.ropaque, 1);
        check("t1_lat3_early", if_b.rvalid1, 0);
        next_cycle(); next_cycle();
        at_sample();
        check("t1_lat3_rvalid1", if_b.rvalid1, 1);
        check("t1_lat3_rdata",   if_b.rdata, 24'h123456);
        next_cycle();

        // contention from reset: grants alternate starting with tank1
        do_reset();
        for (int i = 0; i < 9; i++) begin
            req1 = (i < 6); req2 = (i < 6);
            dir1 = pick_dir(); dir2 = pick_dir();
            offs1 = 10'($urandom); offs2 = 10'($urandom);
            at_sample();
            if (i < 6) begin
                check("alt_gnt1", if_a.gnt1, (i % 2 == 0));
                check("alt_gnt2", if_a.gnt2, (i % 2 == 1));
            end
            if (i >= 3) begin
                check("alt_rvalid1", if_a.rvalid1, (i % 2 == 1));
                check("alt_rvalid2", if_a.rvalid2, (i % 2 == 0));
            end
            next_cycle();
        end

        // tank2, left sprite, key-coloured pixel
        req2 = 1'b1; dir2 = 3'd3; offs2 = 10'd33;
        at_sample();
        check("key_gnt2", if_a.gnt2, 1);
        next_cycle(); req2 = 1'b0;
        next_cycle(); next_cycle();
        at_sample();
        check("key_rvalid2", if_a.rvalid2, 1);
        check("key_rdata",   if_a.rdata, 24'hFF0000);
        check("key_ropaque", if_a.ropaque, 0);
        next_cycle();

        // invalid direction still consumes a slot and returns transparent
        req1 = 1'b1; dir1 = 3'd0; offs1 = 10'd77;
        at_sample();
        check("bad_gnt1", if_a.gnt1, 1);
        next_cycle(); req1 = 1'b0;
        at_sample();
        check("bad_addr", if_a.rom_addr, 0);
        check("bad_sel",  if_a.rom_sel, 0);
        next_cycle(); next_cycle();
        at_sample();
        check("bad_rvalid1", if_a.rvalid1, 1);
        check("bad_rdata",   if_a.rdata, 24'hFF0000);
        check("bad_ropaque", if_a.ropaque, 0);
        next_cycle();

        // reset while requests are in flight
        req1 = 1'b1; dir1 = 3'd2; offs1 = 10'd100;
        next_cycle(); offs1 = 10'd101;
        next_cycle(); Reset = 1'b1; offs1 = 10'd102;
        at_sample();
        check("mid_rst_gnt1", if_a.gnt1, 0);
        next_cycle(); Reset = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            at_sample();
            check("flush_a", {if_a.rvalid1, if_a.rvalid2}, 0);
            check("flush_b", {if_b.rvalid1, if_b.rvalid2}, 0);
            next_cycle();
        end
        req1 = 1'b1; req2 = 1'b1; dir1 = 3'd4; dir2 = 3'd1; offs1 = 10'd9; offs2 = 10'd10;
        at_sample();
        check("post_rst_gnt1", if_a.gnt1, 1);
        next_cycle(); req1 = 1'b0;
        at_sample();
        check("post_rst_gnt2", if_a.gnt2, 1);
        next_cycle(); req2 = 1'b0;
        repeat (6) next_cycle();

        // random traffic with occasional reset
        g1s = 1'b0; g2s = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!req1 || g1s) begin
                req1  = ($urandom_range(0, 3) != 0);
                dir1  = pick_dir();
                offs1 = 10'($urandom);
            end
            if (!req2 || g2s) begin
                req2  = ($urandom_range(0, 3) != 0);
                dir2  = pick_dir();
                offs2 = 10'($urandom);
            end
            Reset = ($urandom_range(0, 299) == 0);
            at_sample();
            g1s = if_a.gnt1;
            g2s = if_a.gnt2;
            next_cycle();
        end
        Reset = 1'b0; req1 = 1'b0; req2 = 1'b0;
        repeat (10) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, expected finish before time 300000");
        $fatal(1);
    end

endmodule

`default_nettype wire
